// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Optional ACCESS watchdog is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr,
  output logic [1:0]         state_dbg
);

  // Handshake: a requester holds req_valid (and its write/addr/wdata slice)
  // until it sees its one-cycle req_ack; the result comes back later as a
  // one-cycle rsp_valid pulse on the same bit, with rsp_rdata/rsp_err.

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   grant;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     cand;
  logic            win_write;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            do_launch;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]   tcnt;
`endif

  assign state_dbg = state;

  // Search last+1, last+2, ... modulo NREQ; first pending requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_write = req_write[i];
        win_addr  = req_addr[i*AW +: AW];
        win_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // A new grant is taken from IDLE, or back-to-back on the completing ACCESS edge.
  assign do_launch = win_found &&
                     ((state == S_IDLE) || ((state == S_ACCESS) && pready));

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= S_IDLE;
      last      <= IW'(NREQ - 1);
      grant     <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: ;
        S_SETUP: begin
          state   <= S_ACCESS;
          penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            rsp_valid[grant] <= 1'b1;
            rsp_rdata        <= pwrite ? '0 : prdata;
            rsp_err          <= pslverr;
            state            <= S_IDLE;
            psel             <= 1'b0;
            penable          <= 1'b0;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid[grant] <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
            state            <= S_IDLE;
            psel             <= 1'b0;
            penable          <= 1'b0;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
`endif
        end
        default: begin
          state   <= S_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase

      // Overrides the ACCESS->IDLE exit when another request is waiting.
      if (do_launch) begin
        req_ack          <= '0;
        req_ack[win_idx] <= 1'b1;
        grant            <= win_idx;
        last             <= win_idx;
        pwrite           <= win_write;
        paddr            <= win_addr;
        pwdata           <= win_wdata;
        state            <= S_SETUP;
        psel             <= 1'b1;
        penable          <= 1'b0;
      end
    end
  end

endmodule
